// File: rtl/iterative_multiplier.sv
// RV32M multiply unit: radix-2 shift-add over XLEN cycles, then a sign-fix
// cycle that selects the low or high product half.
module iterative_multiplier #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] operand1,
  input  logic [XLEN-1:0] operand2,
  input  logic [1:0]      mul_opcode,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned PW = 2 * XLEN;
  localparam int unsigned CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } mul_op_e;

  state_e            state_q, state_d;
  mul_op_e           opcode_q, opcode_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   mcand_q, mcand_d;
  logic [XLEN-1:0]   mplier_q, mplier_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [XLEN-1:0]   result_q, result_d;

  mul_op_e           op_in_c;
  logic              s1_c, s2_c;
  logic [XLEN-1:0]   mag1_c, mag2_c;
  logic [PW-1:0]     partial_c;
  logic [PW-1:0]     sum_c;
  logic [PW-1:0]     prod_c;
  logic              last_c;

  // Operand sign handling and datapath arithmetic.
  always_comb begin
    op_in_c   = mul_op_e'(mul_opcode);
    s1_c      = ((op_in_c == OP_MULH) || (op_in_c == OP_MULHSU)) && operand1[XLEN-1];
    s2_c      = (op_in_c == OP_MULH) && operand2[XLEN-1];
    mag1_c    = s1_c ? ((~operand1) + XLEN'(1)) : operand1;
    mag2_c    = s2_c ? ((~operand2) + XLEN'(1)) : operand2;
    partial_c = PW'(mcand_q) << cnt_q;
    sum_c     = mplier_q[0] ? (acc_q + partial_c) : acc_q;
    prod_c    = neg_q ? ((~acc_q) + PW'(1)) : acc_q;
    last_c    = (cnt_q == CW'(XLEN - 1));
  end

  // Next-state and register updates.
  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    neg_d    = neg_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          opcode_d = op_in_c;
          neg_d    = s1_c ^ s2_c;
          mcand_d  = mag1_c;
          mplier_d = mag2_c;
          acc_d    = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = ST_CALC;
        end
      end
      ST_CALC: begin
        acc_d    = sum_c;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (last_c) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        result_d = (opcode_q == OP_MUL) ? prod_c[XLEN-1:0] : prod_c[PW-1:XLEN];
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      opcode_q <= OP_MUL;
      neg_q    <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      neg_q    <= neg_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_iterative_multiplier.sv
// Directed vector bench for iterative_multiplier: results, latency, busy
// window, ignored start, back-to-back accept and asynchronous abort.
module tb_iterative_multiplier;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] operand1;
  logic [31:0] operand2;
  logic [1:0]  mul_opcode;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int errors = 0;
  int checks = 0;
  logic [31:0] prev_result = 32'h0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [12];

  iterative_multiplier #(.XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .operand1   (operand1),
    .operand2   (operand2),
    .mul_opcode (mul_opcode),
    .busy       (busy),
    .done       (done),
    .result     (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Issue one operation; optionally pulse a stray start before edge k.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int k, input string tag);
    int n;
    int busy_cnt;
    int lat;
    bit got;
    int hold_bad;
    @(negedge clk);
    mul_opcode = op;
    operand1   = a;
    operand2   = b;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    operand1 = $urandom;
    operand2 = $urandom;
    mul_opcode = 2'($urandom_range(0, 3));
    chk({tag, " busy_at_accept"}, 32'(busy), 32'd1);
    chk({tag, " done_low_at_accept"}, 32'(done), 32'd0);
    busy_cnt = 1;
    got      = 1'b0;
    lat      = 0;
    hold_bad = 0;
    n        = 0;
    while (!got && n < 100) begin
      n++;
      if (n == k) begin
        start      = 1'b1;
        operand1   = 32'd3;
        operand2   = 32'd3;
        mul_opcode = 2'b00;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done) begin
        got = 1'b1;
        lat = n;
      end else begin
        if (busy) busy_cnt++;
        if (result !== prev_result) hold_bad++;
      end
    end
    if (!got) begin
      chk({tag, " done_timeout"}, 32'd0, 32'd1);
    end else begin
      chk({tag, " latency"}, 32'(lat), 32'd33);
      chk({tag, " busy_cycles"}, 32'(busy_cnt), 32'd33);
      chk({tag, " busy_low_at_done"}, 32'(busy), 32'd0);
      chk({tag, " result"}, result, exp);
    end
    chk({tag, " result_held"}, 32'(hold_bad), 32'd0);
    prev_result = exp;
  endtask

  initial begin
    int seen;
    vecs[0]  = '{2'b00, 32'h00000007, 32'h00000006, 32'h0000002A};
    vecs[1]  = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000};
    vecs[2]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
    vecs[3]  = '{2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[4]  = '{2'b10, 32'h00000002, 32'h80000000, 32'h00000001};
    vecs[5]  = '{2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[6]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
    vecs[7]  = '{2'b01, 32'hFFFFFFFF, 32'h00000000, 32'h00000000};
    vecs[8]  = '{2'b01, 32'h80000000, 32'h00000001, 32'hFFFFFFFF};
    vecs[9]  = '{2'b00, 32'h12345678, 32'h00000010, 32'h23456780};
    vecs[10] = '{2'b11, 32'h80000000, 32'h00000002, 32'h00000001};
    vecs[11] = '{2'b10, 32'h80000000, 32'h00000002, 32'hFFFFFFFF};

    rst        = 1'b1;
    start      = 1'b0;
    operand1   = 32'h0;
    operand2   = 32'h0;
    mul_opcode = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset result", result, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, 0, $sformatf("vec%0d", i));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d done_one_cycle", i), 32'(done), 32'd0);
    end

    // Stray start at E10 must be ignored.
    run_op(2'b00, 32'd7, 32'd6, 32'h0000002A, 10, "ignore_e10");

    // Back-to-back: second request presented for E34.
    run_op(2'b11, 32'h00010000, 32'h00010000, 32'h00000001, 0, "b2b_first");
    run_op(2'b00, 32'h0000000B, 32'h0000000D, 32'h0000008F, 0, "b2b_second");

    // Asynchronous abort between E15 and E16.
    @(negedge clk);
    mul_opcode = 2'b00;
    operand1   = 32'd7;
    operand2   = 32'd6;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort result", result, 32'h0);
    chk("abort done", 32'(done), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    prev_result = 32'h0;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done || busy) seen++;
    end
    chk("abort no_done", 32'(seen), 32'd0);
    run_op(2'b00, 32'd3, 32'd5, 32'h0000000F, 0, "after_abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
